// File: rtl/multicore_mem_arbiter_if.sv
`default_nettype none
// multicore_mem_arbiter_if: core-side and RAM-side bus bundle for the shared-memory arbiter.
// Rev 1.0
interface multicore_mem_arbiter_if #(
  parameter int NUM_CORES   = 3,
  parameter int DATA_LEN    = 16,
  parameter int ADDRESS_LEN = 8
);
  logic [NUM_CORES-1:0]             core_read;
  logic [NUM_CORES-1:0]             core_write;
  logic [NUM_CORES*ADDRESS_LEN-1:0] core_addr;
  logic [NUM_CORES*DATA_LEN-1:0]    core_wdata;
  logic [NUM_CORES*DATA_LEN-1:0]    core_rdata;
  logic [NUM_CORES-1:0]             core_finish;
  logic [NUM_CORES-1:0]             core_start;
  logic                             ram_read;
  logic                             ram_write;
  logic [ADDRESS_LEN-1:0]           ram_addr;
  logic [DATA_LEN-1:0]              ram_wdata;
  logic [DATA_LEN-1:0]              ram_rdata;

  modport slave (
    input  core_read, core_write, core_addr, core_wdata, core_finish, ram_rdata,
    output core_rdata, core_start, ram_read, ram_write, ram_addr, ram_wdata
  );

  modport master (
    output core_read, core_write, core_addr, core_wdata, core_finish, ram_rdata,
    input  core_rdata, core_start, ram_read, ram_write, ram_addr, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/multicore_mem_arbiter.sv
`default_nettype none
// multicore_mem_arbiter: round-robin single-RAM arbiter for NUM_CORES cores with sticky finish flag.
// Optional barrier sync point enabled by MULTICORE_ARB_BARRIER_EN. Rev 1.0
module multicore_mem_arbiter #(
  parameter int NUM_CORES    = 3,
  parameter int DATA_LEN     = 16,
  parameter int ADDRESS_LEN  = 8,
  parameter int BARRIER_ADDR = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   finish_process_o,
  multicore_mem_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_ACCESS = 3'd2,
    S_RDATA  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic [IDX_W-1:0]              win_q, win_d;
  logic                          wr_q, wr_d;
  logic [NUM_CORES-1:0]          fin_q, fin_d;
  logic [NUM_CORES-1:0]          ack_q, ack_d;
  logic                          start_prev_q;
  logic                          ram_read_q, ram_read_d;
  logic                          ram_write_q, ram_write_d;
  logic [ADDRESS_LEN-1:0]        ram_addr_q, ram_addr_d;
  logic [DATA_LEN-1:0]           ram_wdata_q, ram_wdata_d;
  logic [NUM_CORES*DATA_LEN-1:0] rdata_q, rdata_d;
  logic                          finish_q, finish_d;

  logic [NUM_CORES-1:0]          req_raw, req, serve;
  logic                          start_edge;
  logic                          found;
  logic [IDX_W-1:0]              pick;

  assign req_raw    = bus.core_read | bus.core_write;
  assign start_edge = start_i & ~start_prev_q;
  // An acked core still drives its request during the ack cycle; masking it avoids a duplicate access.
  assign req        = req_raw & ~fin_q & ~ack_q;

`ifdef MULTICORE_ARB_BARRIER_EN
  logic [NUM_CORES-1:0] arr_q, arr_d;
  logic [NUM_CORES-1:0] at_bar;
  logic                 release_bar;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_bar
    assign at_bar[g] = (bus.core_addr[g*ADDRESS_LEN +: ADDRESS_LEN] == ADDRESS_LEN'(BARRIER_ADDR));
  end

  assign serve       = req & ~at_bar;
  // Finished cores count as arrived so a late finisher cannot deadlock the barrier.
  assign release_bar = (state_q == S_ARB) && (&(arr_q | fin_q)) && (|arr_q);

  always_comb begin
    arr_d = arr_q;
    if (state_q == S_ARB) begin
      arr_d = arr_q | (req & at_bar);
    end
    if (release_bar) begin
      arr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arr_q <= '0;
    end else begin
      arr_q <= arr_d;
    end
  end
`else
  logic unused_barrier;
  assign unused_barrier = ^BARRIER_ADDR;
  assign serve          = req;
`endif

  always_comb begin
    int j;
    found = 1'b0;
    pick  = ptr_q;
    j     = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_CORES) begin
        j = j - NUM_CORES;
      end
      if (!found && serve[IDX_W'(j)]) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    wr_d        = wr_q;
    fin_d       = fin_q | bus.core_finish;
    ack_d       = '0;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    finish_d    = finish_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (&fin_q) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end else if (found) begin
          win_d       = pick;
          wr_d        = bus.core_write[pick];
          ram_write_d = bus.core_write[pick];
          ram_read_d  = ~bus.core_write[pick];
          ram_addr_d  = bus.core_addr[pick*ADDRESS_LEN +: ADDRESS_LEN];
          ram_wdata_d = bus.core_wdata[pick*DATA_LEN +: DATA_LEN];
          ptr_d       = (pick == IDX_W'(NUM_CORES-1)) ? '0 : pick + IDX_W'(1);
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (wr_q) begin
          ack_d[win_q] = 1'b1;
          state_d      = S_ARB;
        end else begin
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        rdata_d[win_q*DATA_LEN +: DATA_LEN] = bus.ram_rdata;
        ack_d[win_q]                        = 1'b1;
        state_d                             = S_ARB;
      end
      S_DONE: begin
        if (start_edge) begin
          fin_d    = '0;
          finish_d = 1'b0;
          state_d  = S_ARB;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef MULTICORE_ARB_BARRIER_EN
    if (release_bar) begin
      ack_d = ack_d | arr_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      wr_q         <= 1'b0;
      fin_q        <= '0;
      ack_q        <= '0;
      start_prev_q <= 1'b0;
      ram_read_q   <= 1'b0;
      ram_write_q  <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rdata_q      <= '0;
      finish_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      wr_q         <= wr_d;
      fin_q        <= fin_d;
      ack_q        <= ack_d;
      start_prev_q <= start_i;
      ram_read_q   <= ram_read_d;
      ram_write_q  <= ram_write_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rdata_q      <= rdata_d;
      finish_q     <= finish_d;
    end
  end

  assign busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign finish_process_o = finish_q;
  assign bus.core_start   = {NUM_CORES{busy_o}} & ~fin_q & (~req_raw | ack_q);
  assign bus.core_rdata   = rdata_q;
  assign bus.ram_read     = ram_read_q;
  assign bus.ram_write    = ram_write_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wdata    = ram_wdata_q;
endmodule
`default_nettype wire
